// File: rtl/reset_ctrl.sv
// Reset sequencer: holds both resets, releases peripherals, then the CPU after a gap.
// Optional firmware-request lockout after entering RUN is enabled by RESET_CTRL_HOLDOFF_EN.
module reset_ctrl #(
    parameter int RESET_CYCLES   = 200,
    parameter int RELEASE_GAP    = 16,
    parameter int HOLDOFF_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ext_rst_req,
    input  logic       wdt_rst_req,
    input  logic       fw_rst_req,
    output logic       periph_rst_n,
    output logic       cpu_rst_n,
    output logic       busy,
    output logic [1:0] rst_cause,
    output logic [7:0] warm_rst_cnt
);

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_GAP    = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(RESET_CYCLES - 1);
    localparam logic [7:0] GAP_LAST  = 8'(RELEASE_GAP - 1);

    if (RESET_CYCLES < 1 || RESET_CYCLES > 255) begin : g_bad_reset_cycles
        $error("reset_ctrl: RESET_CYCLES out of range 1..255");
    end
    if (RELEASE_GAP < 0 || RELEASE_GAP > 255) begin : g_bad_release_gap
        $error("reset_ctrl: RELEASE_GAP out of range 0..255");
    end
    if (HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > 255) begin : g_bad_holdoff
        $error("reset_ctrl: HOLDOFF_CYCLES out of range 1..255");
    end

    state_t     state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       fw_eff;
    logic       req;

`ifdef RESET_CTRL_HOLDOFF_EN
    logic [7:0] holdoff_reg;

    // Lockout reloads on every RUN entry and then drains regardless of state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            holdoff_reg <= '0;
        end else if (state_next == ST_RUN && state_reg != ST_RUN) begin
            holdoff_reg <= 8'(HOLDOFF_CYCLES);
        end else if (holdoff_reg != 8'd0) begin
            holdoff_reg <= holdoff_reg - 8'd1;
        end
    end

    assign fw_eff = fw_rst_req & (holdoff_reg == 8'd0);
`else
    assign fw_eff = fw_rst_req;
`endif

    assign req = ext_rst_req | wdt_rst_req | fw_eff;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 8'd1;
        case (state_reg)
            ST_ASSERT: begin
                if (cnt_reg == HOLD_LAST) begin
                    state_next = (RELEASE_GAP == 0) ? ST_RUN : ST_GAP;
                    cnt_next   = '0;
                end
            end
            ST_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end
            end
            ST_RUN: begin
                cnt_next = '0;
            end
            default: begin
                state_next = ST_ASSERT;
                cnt_next   = '0;
            end
        endcase
        // A request overrides everything, so a request in ASSERT restarts the hold window.
        if (req) begin
            state_next = ST_ASSERT;
            cnt_next   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_ASSERT;
            cnt_reg      <= '0;
            periph_rst_n <= 1'b0;
            cpu_rst_n    <= 1'b0;
            busy         <= 1'b1;
            rst_cause    <= 2'b00;
            warm_rst_cnt <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            // Outputs decode the next state so they flip on the same edge as the state.
            periph_rst_n <= (state_next != ST_ASSERT);
            cpu_rst_n    <= (state_next == ST_RUN);
            busy         <= (state_next != ST_RUN);
            if (req) begin
                if (ext_rst_req) begin
                    rst_cause <= 2'b01;
                end else if (wdt_rst_req) begin
                    rst_cause <= 2'b10;
                end else begin
                    rst_cause <= 2'b11;
                end
                if (warm_rst_cnt != 8'hFF) begin
                    warm_rst_cnt <= warm_rst_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_reset_ctrl.sv
// Self-checking bench for reset_ctrl: expected release records are queued at stimulus time
// and popped when the DUT releases its resets; a second instance covers RELEASE_GAP = 0.
`timescale 1ns/1ps
module tb_reset_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ext_rst_req, wdt_rst_req, fw_rst_req;
    logic       periph_rst_n, cpu_rst_n, busy;
    logic [1:0] rst_cause;
    logic [7:0] warm_rst_cnt;

    logic       rst_b, wdt_b, zero_b;
    logic       periph_b, cpu_b, busy_b;
    logic [1:0] cause_b;
    logic [7:0] cnt_b;

    reset_ctrl dut (
        .clk(clk), .rst(rst), .ext_rst_req(ext_rst_req), .wdt_rst_req(wdt_rst_req),
        .fw_rst_req(fw_rst_req), .periph_rst_n(periph_rst_n), .cpu_rst_n(cpu_rst_n),
        .busy(busy), .rst_cause(rst_cause), .warm_rst_cnt(warm_rst_cnt)
    );

    reset_ctrl #(.RELEASE_GAP(0)) u_gap0 (
        .clk(clk), .rst(rst_b), .ext_rst_req(zero_b), .wdt_rst_req(wdt_b),
        .fw_rst_req(zero_b), .periph_rst_n(periph_b), .cpu_rst_n(cpu_b),
        .busy(busy_b), .rst_cause(cause_b), .warm_rst_cnt(cnt_b)
    );

    typedef struct {
        string      name;
        int         periph_n;
        int         cpu_n;
        logic [1:0] cause;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_cnt = 0;

    task automatic wait_periph(output int n);
        n = -1;
        for (int i = 1; i <= 1000; i++) begin
            @(posedge clk); @(negedge clk);
            if (periph_rst_n === 1'b1) begin n = i; return; end
        end
    endtask

    task automatic wait_cpu(input int start, output int n);
        n = -1;
        for (int i = start + 1; i <= start + 1000; i++) begin
            @(posedge clk); @(negedge clk);
            if (cpu_rst_n === 1'b1) begin n = i; return; end
        end
    endtask

    task automatic pulse(input logic e, input logic w, input logic f);
        ext_rst_req = e; wdt_rst_req = w; fw_rst_req = f;
        @(posedge clk); @(negedge clk);
        ext_rst_req = 1'b0; wdt_rst_req = 1'b0; fw_rst_req = 1'b0;
    endtask

    // Pops one expected release record and compares it against a measured release.
    task automatic release_and_check(input int np_in, input logic skip_periph);
        exp_t e; int np, nc; logic busy_mid;
        np = np_in;
        if (!skip_periph) wait_periph(np);
        busy_mid = busy;
        wait_cpu(np, nc);
        e = sb.pop_front();
        checks++; if (np !== e.periph_n) begin errors++; $display("FAIL %s periph_edges got %0d expected %0d", e.name, np, e.periph_n); end
        checks++; if (nc !== e.cpu_n) begin errors++; $display("FAIL %s cpu_edges got %0d expected %0d", e.name, nc, e.cpu_n); end
        checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL %s busy_in_gap got %b expected 1", e.name, busy_mid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_in_run got %b expected 0", e.name, busy); end
        checks++; if (rst_cause !== e.cause) begin errors++; $display("FAIL %s rst_cause got %b expected %b", e.name, rst_cause, e.cause); end
        checks++; if (warm_rst_cnt !== e.cnt) begin errors++; $display("FAIL %s warm_rst_cnt got %0d expected %0d", e.name, warm_rst_cnt, e.cnt); end
        $display("txn %s: periph after %0d edges, cpu after %0d edges, cause %b, count %0d", e.name, np, nc, rst_cause, warm_rst_cnt);
    endtask

    task automatic test_reset();
        rst = 1'b1; ext_rst_req = 1'b0; wdt_rst_req = 1'b0; fw_rst_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({periph_rst_n, cpu_rst_n, busy} !== 3'b001) begin errors++; $display("FAIL reset_outputs got %b expected 001", {periph_rst_n, cpu_rst_n, busy}); end
        checks++; if ({rst_cause, warm_rst_cnt} !== 10'd0) begin errors++; $display("FAIL reset_status got cause %b cnt %0d expected 00/0", rst_cause, warm_rst_cnt); end
        $display("txn reset: outputs %b%b%b cause %b count %0d", periph_rst_n, cpu_rst_n, busy, rst_cause, warm_rst_cnt);
    endtask

    task automatic test_por();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        sb.push_back('{"por", 200, 216, 2'b00, 8'd0});
        release_and_check(0, 1'b0);
    endtask

    task automatic test_wdt();
        pulse(1'b0, 1'b1, 1'b0);
        exp_cnt++;
        checks++; if ({periph_rst_n, cpu_rst_n, busy} !== 3'b001) begin errors++; $display("FAIL wdt_assert got %b expected 001", {periph_rst_n, cpu_rst_n, busy}); end
        sb.push_back('{"wdt", 200, 216, 2'b10, 8'(exp_cnt)});
        release_and_check(0, 1'b0);
    endtask

    task automatic test_coincide();
        logic early;
        pulse(1'b1, 1'b1, 1'b1);
        exp_cnt++;
        checks++; if (rst_cause !== 2'b01 || warm_rst_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL coincide got cause %b cnt %0d expected 01/%0d", rst_cause, warm_rst_cnt, exp_cnt); end
        early = 1'b0;
        ext_rst_req = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); @(negedge clk);
            exp_cnt++;
            if (periph_rst_n !== 1'b0) early = 1'b1;
        end
        ext_rst_req = 1'b0;
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL ext_hold periph released while ext held got 1 expected 0"); end
        sb.push_back('{"ext_hold", 200, 216, 2'b01, 8'(exp_cnt)});
        release_and_check(0, 1'b0);
    endtask

    task automatic test_fw_gap();
        int np;
        pulse(1'b0, 1'b1, 1'b0);
        exp_cnt++;
        wait_periph(np);
        checks++; if (np !== 200) begin errors++; $display("FAIL fw_gap periph_edges got %0d expected 200", np); end
        repeat (5) begin @(posedge clk); @(negedge clk); end
        pulse(1'b0, 1'b0, 1'b1);
        exp_cnt++;
        checks++; if ({periph_rst_n, cpu_rst_n} !== 2'b00) begin errors++; $display("FAIL fw_gap resets got %b expected 00", {periph_rst_n, cpu_rst_n}); end
        sb.push_back('{"fw_gap", 200, 216, 2'b11, 8'(exp_cnt)});
        release_and_check(0, 1'b0);
    endtask

`ifdef RESET_CTRL_HOLDOFF_EN
    task automatic test_holdoff();
        logic dropped;
        repeat (9) begin @(posedge clk); @(negedge clk); end
        pulse(1'b0, 1'b0, 1'b1);
        dropped = 1'b1;
        repeat (5) begin
            if (cpu_rst_n !== 1'b1 || warm_rst_cnt !== 8'(exp_cnt)) dropped = 1'b0;
            @(posedge clk); @(negedge clk);
        end
        checks++; if (dropped !== 1'b1) begin errors++; $display("FAIL holdoff_fw10 got cpu %b cnt %0d expected 1/%0d", cpu_rst_n, warm_rst_cnt, exp_cnt); end
        repeat (54) begin @(posedge clk); @(negedge clk); end
        pulse(1'b0, 1'b0, 1'b1);
        exp_cnt++;
        checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL holdoff_fw70 cpu got %b expected 0", cpu_rst_n); end
        sb.push_back('{"holdoff_fw70", 200, 216, 2'b11, 8'(exp_cnt)});
        release_and_check(0, 1'b0);
        repeat (9) begin @(posedge clk); @(negedge clk); end
        pulse(1'b0, 1'b1, 1'b0);
        exp_cnt++;
        checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL holdoff_wdt10 cpu got %b expected 0", cpu_rst_n); end
        sb.push_back('{"holdoff_wdt10", 200, 216, 2'b10, 8'(exp_cnt)});
        release_and_check(0, 1'b0);
    endtask
`endif

    task automatic test_rst_mid_gap();
        int np;
        pulse(1'b0, 1'b1, 1'b0);
        wait_periph(np);
        repeat (3) begin @(posedge clk); @(negedge clk); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({periph_rst_n, cpu_rst_n, busy} !== 3'b001) begin errors++; $display("FAIL mid_gap_rst outputs got %b expected 001", {periph_rst_n, cpu_rst_n, busy}); end
        checks++; if ({rst_cause, warm_rst_cnt} !== 10'd0) begin errors++; $display("FAIL mid_gap_rst status got cause %b cnt %0d expected 00/0", rst_cause, warm_rst_cnt); end
        $display("txn mid_gap_rst: outputs %b%b%b cause %b count %0d", periph_rst_n, cpu_rst_n, busy, rst_cause, warm_rst_cnt);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        sb.push_back('{"por_after_mid_gap", 200, 216, 2'b00, 8'd0});
        release_and_check(0, 1'b0);
    endtask

    task automatic test_gap0();
        exp_t e; int np; logic cpu_early;
        @(negedge clk);
        rst_b = 1'b0;
        sb.push_back('{"gap0", 200, 200, 2'b10, 8'd255});
        np = -1; cpu_early = 1'b0;
        for (int i = 1; i <= 1000; i++) begin
            @(posedge clk); @(negedge clk);
            if (periph_b === 1'b1) begin np = i; break; end
            if (cpu_b !== 1'b0) cpu_early = 1'b1;
        end
        e = sb.pop_front();
        checks++; if (np !== e.periph_n) begin errors++; $display("FAIL gap0 periph_edges got %0d expected %0d", np, e.periph_n); end
        checks++; if (cpu_b !== 1'b1 || cpu_early !== 1'b0) begin errors++; $display("FAIL gap0 cpu_same_edge got cpu %b early %b expected 1/0", cpu_b, cpu_early); end
        for (int i = 1; i <= 256; i++) begin
            wdt_b = 1'b1; @(posedge clk); @(negedge clk);
            wdt_b = 1'b0; @(posedge clk); @(negedge clk);
            if (i == 254) begin
                checks++; if (cnt_b !== 8'd254) begin errors++; $display("FAIL gap0 count_254 got %0d expected 254", cnt_b); end
            end
        end
        checks++; if (cnt_b !== e.cnt) begin errors++; $display("FAIL gap0 saturate got %0d expected %0d", cnt_b, e.cnt); end
        checks++; if (cause_b !== e.cause) begin errors++; $display("FAIL gap0 cause got %b expected %b", cause_b, e.cause); end
        $display("txn gap0: periph and cpu after %0d edges, count %0d cause %b", np, cnt_b, cause_b);
    endtask

    initial begin
        rst_b = 1'b1; wdt_b = 1'b0; zero_b = 1'b0;
        test_reset();
        test_por();
        test_wdt();
        test_coincide();
        test_fw_gap();
`ifdef RESET_CTRL_HOLDOFF_EN
        test_holdoff();
`endif
        test_rst_mid_gap();
        test_gap0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reset_ctrl.md
Name: reset_ctrl

Overview:
Reset controller that sequences the application_fpga system resets after power-on and on warm-reset requests.
- Arbitrates three request sources: external pin, watchdog and firmware.
- Holds all resets asserted for a fixed time, then releases peripherals first and the CPU a programmable gap later.
- Records the cause of the last reset and a saturating warm-reset count for firmware readback.

Parameters:
RESET_CYCLES, 200, hold time in clk cycles with both resets asserted; legal range 1..255.
RELEASE_GAP, 16, clk cycles between periph_rst_n release and cpu_rst_n release; legal range 0..255.
HOLDOFF_CYCLES, 64, firmware-request lockout after entering RUN; used only with RESET_CTRL_HOLDOFF_EN; legal range 1..255.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset (power-on reset).
ext_rst_req  input  1  external reset request, level, synchronous to clk.
wdt_rst_req  input  1  watchdog reset request, single-cycle pulse.
fw_rst_req  input  1  firmware reset request, single-cycle pulse.
periph_rst_n  output  1  active-low peripheral reset, registered.
cpu_rst_n  output  1  active-low CPU reset, registered.
busy  output  1  high whenever state is not RUN.
rst_cause  output  2  cause of the last reset: 00 POR, 01 ext, 10 wdt, 11 fw.
warm_rst_cnt  output  8  count of warm resets since POR; saturates at 255.

Behaviour:
- Reset values while rst is high:
  - state ASSERT, hold/gap counter 0.
  - periph_rst_n 0, cpu_rst_n 0, busy 1.
  - rst_cause 00, warm_rst_cnt 0, holdoff counter 0.
- Any warm request is `req = ext_rst_req | wdt_rst_req | fw_rst_req_eff`.
  - fw_rst_req_eff = fw_rst_req, except under the holdoff rule in Optional Feature.
- Cause priority when requests coincide: ext > wdt > fw.
- The 8-bit counter is shared between ASSERT and GAP. It is cleared on every state entry.
- ASSERT:
  - periph_rst_n = 0, cpu_rst_n = 0.
  - Counter increments each cycle.
  - When counter == RESET_CYCLES-1 and no req: go to GAP, or to RUN if RELEASE_GAP == 0.
- GAP:
  - periph_rst_n = 1, cpu_rst_n = 0.
  - Counter increments each cycle.
  - When counter == RELEASE_GAP-1 and no req: go to RUN.
- RUN:
  - Both resets = 1, busy = 0.
- Request handling:
  - Any req in any state: next state ASSERT, counter cleared, rst_cause updated per priority, warm_rst_cnt += 1 (saturating).
  - In ASSERT, a req therefore restarts the hold window.
  - ext_rst_req held high keeps the block in ASSERT indefinitely. The count increments once per cycle in which the level is sampled high, saturating.
- Outputs are registered. Transitions take effect on the clk edge after the deciding condition.
- Timing from the first clk edge with rst low:
  - periph_rst_n rises after exactly RESET_CYCLES edges.
  - cpu_rst_n rises RELEASE_GAP edges after that.
- Reset mid-operation: rst asserted in any state immediately (asynchronously) forces the reset values, including rst_cause 00 and warm_rst_cnt 0.
- No output glitches: periph_rst_n and cpu_rst_n each change at most once per edge and come directly from flops.

Optional Feature:
RESET_CTRL_HOLDOFF_EN
- Defined:
  - On each entry to RUN, a holdoff counter loads HOLDOFF_CYCLES and decrements per cycle down to 0.
  - While it is nonzero, fw_rst_req_eff = 0 and the pulse is dropped, not queued.
  - ext and wdt requests are always honoured.
  - Purpose: prevents firmware reset storms.
- Undefined: holdoff logic is absent and fw_rst_req_eff = fw_rst_req at all times.

Test Plan:
1. POR with defaults: release rst, count edges -> periph_rst_n rises at edge 200, cpu_rst_n at edge 216, busy falls with cpu_rst_n; rst_cause=00, warm_rst_cnt=0.
2. In RUN, pulse wdt_rst_req one cycle -> next edge both resets 0, rst_cause=10, warm_rst_cnt=1; periph release 200 edges later, cpu release 16 after that.
3. Same-cycle ext_rst_req, wdt_rst_req and fw_rst_req in RUN -> rst_cause=01, warm_rst_cnt increments by exactly 1. Then hold ext high 50 cycles -> stays in ASSERT; release timing counts from the last high cycle.
4. fw_rst_req during GAP (counter=5) -> periph_rst_n returns to 0 next edge, hold restarts from 0, rst_cause=11.
5. RELEASE_GAP=0 build -> periph_rst_n and cpu_rst_n rise on the same edge (edge 200). Then drive 256 wdt pulses -> warm_rst_cnt saturates at 255.
6. RESET_CTRL_HOLDOFF_EN defined, HOLDOFF_CYCLES=64:
   - fw pulse 10 cycles after RUN entry -> ignored, cpu_rst_n stays 1.
   - fw pulse 70 cycles after RUN entry -> reset taken.
   - wdt pulse at 10 cycles -> reset taken.
   - Also assert rst mid-GAP -> immediate reset values.
